// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins ties; fetch is granted after MAX_DATA_STREAK consecutive data wins.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_e;

    state_e              state_q;
    logic [SW-1:0]       streak_q, streak_d;
    logic                if_ack_q, d_ack_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                mem_valid_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wstrb_q;

    logic if_elig, d_elig, grant_if, grant_d;

    // The ack cycle still shows the retiring request, so it must not re-arbitrate.
    assign if_elig  = if_req & ~if_ack_q;
    assign d_elig   = d_req  & ~d_ack_q;
    assign grant_if = (state_q == S_IDLE) & if_elig & (~d_elig | (streak_q == STREAK_MAX));
    assign grant_d  = (state_q == S_IDLE) & d_elig & ~grant_if;

    always_comb begin
        streak_d = streak_q;
        if (grant_if) begin
            streak_d = '0;
        end else if (grant_d) begin
            if (!if_elig)
                streak_d = '0;
            else if (streak_q != STREAK_MAX)
                streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    streak_q <= streak_d;
                    if (grant_if) begin
                        state_q     <= S_BUSY_IF;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                    end else if (grant_d) begin
                        state_q     <= S_BUSY_D;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_wstrb_q <= d_we ? d_wstrb : '0;
                    end
                end
                S_BUSY_IF: begin
                    if (mem_ready) begin
                        if_rdata_q  <= mem_rdata;
                        if_ack_q    <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_BUSY_D: begin
                    if (mem_ready) begin
                        if (!mem_we_q)
                            d_rdata_q <= mem_rdata;
                        d_ack_q     <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = d_req & ~d_ack_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we, mem_ready;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [3:0]    d_wstrb;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic          if_ack, d_ack, stall_if, stall_mem, mem_valid, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;

    int tests = 0;
    int fails = 0;

    // reference model state: owner 0 = none, 1 = fetch, 2 = data
    int            m_owner;
    int            m_streak;
    logic          m_valid, m_we, m_if_ack, m_d_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]    m_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic model_update();
        bit ie, de, nia, nda;
        if (reset) begin
            m_owner = 0; m_streak = 0; m_valid = 0; m_we = 0; m_addr = '0;
            m_wdata = '0; m_wstrb = '0; m_if_ack = 0; m_d_ack = 0;
            m_if_rdata = '0; m_d_rdata = '0;
        end else begin
            ie  = if_req && !m_if_ack;
            de  = d_req && !m_d_ack;
            nia = 0;
            nda = 0;
            if (m_owner == 0) begin
                if (ie && (!de || m_streak == MAX)) begin
                    m_owner = 1; m_valid = 1; m_we = 0; m_addr = if_addr;
                    m_wstrb = '0; m_streak = 0;
                end else if (de) begin
                    m_owner = 2; m_valid = 1; m_we = d_we; m_addr = d_addr;
                    m_wdata = d_wdata; m_wstrb = d_we ? d_wstrb : 4'b0000;
                    m_streak = ie ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
                end
            end else if (mem_ready) begin
                if (m_owner == 1) begin
                    m_if_rdata = mem_rdata; nia = 1;
                end else begin
                    if (!m_we) m_d_rdata = mem_rdata;
                    nda = 1;
                end
                m_valid = 0;
                m_owner = 0;
            end
            m_if_ack = nia;
            m_d_ack  = nda;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", mem_valid); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", mem_we); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        tests++; if (mem_wstrb !== 4'h0) begin fails++; $display("FAIL rst_wstrb: got %h want 0", mem_wstrb); end
        tests++; if ({if_ack, d_ack} !== 2'b00) begin fails++; $display("FAIL rst_acks: got %b want 00", {if_ack, d_ack}); end
        tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        reset = 0;
        tick();
    endtask

    task automatic test_zero_wait_fetch();
        if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h00500093;
        #1;
        tests++; if (stall_if !== 1'b1) begin fails++; $display("FAIL zw_stall_c0: got %b want 1", stall_if); end
        tick();
        tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin fails++; $display("FAIL zw_c1: got valid=%b addr=%h we=%b want 1/100/0", mem_valid, mem_addr, mem_we); end
        tests++; if (stall_if !== 1'b1) begin fails++; $display("FAIL zw_stall_c1: got %b want 1", stall_if); end
        tick();
        tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h00500093) begin fails++; $display("FAIL zw_ack: got ack=%b rdata=%h want 1/00500093", if_ack, if_rdata); end
        tests++; if (stall_if !== 1'b0 || mem_valid !== 1'b0) begin fails++; $display("FAIL zw_c2: got stall=%b valid=%b want 0/0", stall_if, mem_valid); end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_wait_states();
        d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 0; mem_rdata = 32'hCAFE0001;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_wstrb !== 4'h0 || d_ack !== 1'b0) begin
                fails++; $display("FAIL ws_hold c%0d: got valid=%b addr=%h strb=%h ack=%b want 1/200/0/0", i, mem_valid, mem_addr, mem_wstrb, d_ack);
            end
            tests++; if (stall_mem !== 1'b1) begin fails++; $display("FAIL ws_stall c%0d: got %b want 1", i, stall_mem); end
            if (i == 2) d_addr = 32'h300;
            if (i == 4) mem_ready = 1;
            tick();
        end
        tests++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE0001) begin fails++; $display("FAIL ws_ack: got ack=%b rdata=%h want 1/cafe0001", d_ack, d_rdata); end
        d_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_contention();
        if_req = 1; if_addr = 32'h140; d_req = 1; d_we = 0; d_addr = 32'h240;
        mem_ready = 1; mem_rdata = 32'h11110000;
        tick();
        tests++; if (mem_addr !== 32'h240) begin fails++; $display("FAIL ct_first: got addr %h want 240", mem_addr); end
        tick();
        tests++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin fails++; $display("FAIL ct_dack: got d=%b i=%b want 1/0", d_ack, if_ack); end
        mem_rdata = 32'h22220000;
        tick();
        d_req = 0;
        tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h140) begin fails++; $display("FAIL ct_ifgrant: got valid=%b addr=%h want 1/140", mem_valid, mem_addr); end
        tick();
        tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h22220000) begin fails++; $display("FAIL ct_ifack: got ack=%b rdata=%h want 1/22220000", if_ack, if_rdata); end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_starvation();
        int dacks = 0;
        mem_ready = 1; if_addr = 32'h180; d_we = 0;
        for (int k = 0; k < MAX; k++) begin
            if_req = 1; d_req = 1; d_addr = 32'h400 + 32'(k * 4); mem_rdata = 32'(k);
            tick();
            tests++; if (mem_addr !== 32'h400 + 32'(k * 4)) begin fails++; $display("FAIL sv_dgrant%0d: got addr %h want %h", k, mem_addr, 32'h400 + 32'(k * 4)); end
            tick();
            if (d_ack === 1'b1) dacks++;
            if_req = 0;
            tick();
        end
        tests++; if (dacks != MAX) begin fails++; $display("FAIL sv_dacks: got %0d want %0d", dacks, MAX); end
        if_req = 1; d_req = 1; d_addr = 32'h500; mem_rdata = 32'h0000F00D;
        tick();
        tests++; if (mem_addr !== 32'h180) begin fails++; $display("FAIL sv_ifgrant: got addr %h want 180", mem_addr); end
        tick();
        tests++; if (if_ack !== 1'b1) begin fails++; $display("FAIL sv_ifack: got %b want 1", if_ack); end
        tick();
        tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h500) begin fails++; $display("FAIL sv_resume: got valid=%b addr=%h want 1/500", mem_valid, mem_addr); end
        tick();
        tests++; if (d_ack !== 1'b1) begin fails++; $display("FAIL sv_resume_ack: got %b want 1", d_ack); end
        if_req = 0;
        tick();
        if_req = 1; d_addr = 32'h504;
        tick();
        tests++; if (mem_addr !== 32'h504) begin fails++; $display("FAIL sv_streak_reset: got addr %h want 504", mem_addr); end
        tick();
        if_req = 0; d_req = 0; mem_ready = 0;
        tick();
        tick();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 1; mem_rdata = 32'h12345678;
        tick();
        tick();
        tests++; if (d_rdata !== 32'h12345678) begin fails++; $display("FAIL st_preload: got %h want 12345678", d_rdata); end
        d_req = 0;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h380; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
        tick();
        tests++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL st_bus: got we=%b strb=%b wdata=%h want 1/0011/deadbeef", mem_we, mem_wstrb, mem_wdata);
        end
        mem_ready = 1;
        tick();
        tests++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin fails++; $display("FAIL st_ack: got ack=%b rdata=%h want 1/12345678", d_ack, d_rdata); end
        d_req = 0; d_we = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        if_req = 1; if_addr = 32'h1C0; mem_ready = 0; mem_rdata = 32'hABCD0123;
        tick();
        tick();
        reset = 1;
        tick();
        tests++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin fails++; $display("FAIL rm_clear: got valid=%b addr=%h strb=%h want 0/0/0", mem_valid, mem_addr, mem_wstrb); end
        tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin fails++; $display("FAIL rm_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        reset = 0; mem_ready = 1; if_req = 0;
        tick();
        tests++; if (if_ack !== 1'b0 || mem_valid !== 1'b0 || if_rdata !== 32'h0) begin fails++; $display("FAIL rm_noack: got ack=%b valid=%b rdata=%h want 0/0/0", if_ack, mem_valid, if_rdata); end
        mem_ready = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            d_req     = ($urandom_range(0, 3) != 0);
            d_we      = $urandom_range(0, 1) == 1;
            if_addr   = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_wstrb   = 4'($urandom);
            mem_ready = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            #1;
            tests++; if (stall_if !== (if_req & ~m_if_ack) || stall_mem !== (d_req & ~m_d_ack)) begin
                fails++; $display("FAIL rnd_stall c%0d: got %b%b want %b%b", c, stall_if, stall_mem, if_req & ~m_if_ack, d_req & ~m_d_ack);
            end
            tick();
            tests++; if (mem_valid !== m_valid) begin fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, mem_valid, m_valid); end
            tests++; if (if_ack !== m_if_ack || d_ack !== m_d_ack) begin fails++; $display("FAIL rnd_ack c%0d: got %b%b want %b%b", c, if_ack, d_ack, m_if_ack, m_d_ack); end
            tests++; if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin fails++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h/%h", c, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end
            if (m_valid) begin
                tests++; if (mem_addr !== m_addr || mem_we !== m_we || mem_wstrb !== m_wstrb) begin
                    fails++; $display("FAIL rnd_bus c%0d: got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_we, mem_wstrb, m_addr, m_we, m_wstrb);
                end
                if (m_we) begin
                    tests++; if (mem_wdata !== m_wdata) begin fails++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, m_wdata); end
                end
            end
        end
        reset = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_wait_states();
        test_contention();
        test_starvation();
        test_store();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
